// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter/sequencer muxing 8 W-bit requester lanes onto one valid/ready output.
// Latency: grant registered 1 cycle after REQ seen in IDLE; Y/Y_VALID combinational during GRANT.
// Backpressure: Y_READY low holds the beat and the count; grant ends after BURST_MAX beats or on withdrawal.
module rr_mux8_arbiter #(
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [7:0]     REQ,
  input  logic [8*W-1:0] DIN,
  input  logic           Y_READY,
  output logic [W-1:0]   Y,
  output logic           Y_VALID,
  output logic [2:0]     SEL,
  output logic [7:0]     GNT,
  output logic           BUSY
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;

  logic       win_vld;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       busy;
  logic       req_sel;
  logic       accept;
  logic [W-1:0] lane_dat;

  // Pick the first requester after ptr_q; scanning offsets high-to-low lets the nearest one win.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = 3'd0;
    scan_idx = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      scan_idx = ptr_q + 3'(i);
      if (REQ[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Output channel: only the granted lane is visible, and Y is zeroed whenever it is not valid.
  always_comb begin
    busy     = (state_q == ST_GRANT);
    req_sel  = REQ[sel_q];
    lane_dat = DIN[sel_q*W +: W];
    Y_VALID  = busy & req_sel;
    accept   = Y_VALID & Y_READY;
    Y        = Y_VALID ? lane_dat : '0;
  end

  // Next-state: grant from IDLE, then leave on withdrawal or on the last accepted beat of the burst.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (state_q == ST_IDLE) begin
      if (win_vld) begin
        state_d = ST_GRANT;
        sel_d   = win_idx;
        gnt_d   = 8'd1 << win_idx;
        cnt_d   = 8'd0;
      end
    end else begin
      if (!req_sel || (accept && cnt_q == CNT_LAST)) begin
        state_d = ST_IDLE;
        ptr_d   = sel_q;
        gnt_d   = 8'd0;
        cnt_d   = 8'd0;
      end else if (accept) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State registers; reset puts requester 0 at top priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign SEL  = sel_q;
  assign GNT  = gnt_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed-vector bench for rr_mux8_arbiter (BURST_MAX=4 main instance, BURST_MAX=1 second instance).
module tb_rr_mux8_arbiter;

  logic        CLK;
  logic        RST;
  logic [7:0]  REQ;
  logic [63:0] DIN;
  logic        Y_READY;
  logic [7:0]  Y;
  logic        Y_VALID;
  logic [2:0]  SEL;
  logic [7:0]  GNT;
  logic        BUSY;

  logic        b_rst;
  logic [7:0]  b_req;
  logic        b_rdy;
  logic [7:0]  b_y;
  logic        b_yv;
  logic [2:0]  b_sel;
  logic [7:0]  b_gnt;
  logic        b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux8_arbiter #(.W(8), .BURST_MAX(4)) u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN), .Y_READY(Y_READY),
    .Y(Y), .Y_VALID(Y_VALID), .SEL(SEL), .GNT(GNT), .BUSY(BUSY)
  );

  rr_mux8_arbiter #(.W(8), .BURST_MAX(1)) u_b1 (
    .CLK(CLK), .RST(b_rst), .REQ(b_req), .DIN(DIN), .Y_READY(b_rdy),
    .Y(b_y), .Y_VALID(b_yv), .SEL(b_sel), .GNT(b_gnt), .BUSY(b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    logic       e_yv;
    logic [7:0] e_y;
    logic       e_busy;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic rdy,
                              input logic [7:0] g, input logic [2:0] s, input logic yv,
                              input logic [7:0] y, input logic b);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy;
    v.e_gnt = g; v.e_sel = s; v.e_yv = yv; v.e_y = y; v.e_busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int beats;
    int lane;
    logic [7:0] eg;

    RST = 1'b1; REQ = 8'h00; Y_READY = 1'b0;
    b_rst = 1'b1; b_req = 8'h00; b_rdy = 1'b0;
    // lanes 7..0
    DIN = {8'h77, 8'h66, 8'h5C, 8'h44, 8'h33, 8'hA5, 8'h22, 8'h11};

    // reset; single requester lane 2 with re-grant
    tbl[0]  = mk(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 8'h04, 1, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 2; i <= 5; i++) tbl[i] = mk(0, 8'h04, 1, 8'h04, 2, 1, 8'hA5, 1);
    tbl[6]  = mk(0, 8'h04, 1, 8'h00, 2, 0, 8'h00, 0);
    tbl[7]  = mk(0, 8'h04, 1, 8'h04, 2, 1, 8'hA5, 1);
    tbl[8]  = mk(0, 8'h00, 1, 8'h04, 2, 0, 8'h00, 1);
    // back-pressure on lane 5: 6 stalled cycles then 4 beats
    tbl[9]  = mk(0, 8'h20, 0, 8'h00, 2, 0, 8'h00, 0);
    for (int i = 10; i <= 15; i++) tbl[i] = mk(0, 8'h20, 0, 8'h20, 5, 1, 8'h5C, 1);
    for (int i = 16; i <= 19; i++) tbl[i] = mk(0, 8'h20, 1, 8'h20, 5, 1, 8'h5C, 1);
    tbl[20] = mk(0, 8'h00, 1, 8'h00, 5, 0, 8'h00, 0);
    // reset, then REQ=81: lane 0 withdraws after 2 beats, lane 7 goes next
    tbl[21] = mk(1, 8'h81, 1, 8'h00, 0, 0, 8'h00, 0);
    tbl[22] = mk(0, 8'h81, 1, 8'h00, 0, 0, 8'h00, 0);
    tbl[23] = mk(0, 8'h81, 1, 8'h01, 0, 1, 8'h11, 1);
    tbl[24] = mk(0, 8'h81, 1, 8'h01, 0, 1, 8'h11, 1);
    tbl[25] = mk(0, 8'h80, 1, 8'h01, 0, 0, 8'h00, 1);
    tbl[26] = mk(0, 8'h80, 1, 8'h00, 0, 0, 8'h00, 0);
    tbl[27] = mk(0, 8'h80, 1, 8'h80, 7, 1, 8'h77, 1);
    for (int i = 28; i <= 30; i++) tbl[i] = mk(0, 8'h81, 1, 8'h80, 7, 1, 8'h77, 1);
    tbl[31] = mk(0, 8'h81, 1, 8'h00, 7, 0, 8'h00, 0);
    tbl[32] = mk(0, 8'h81, 1, 8'h01, 0, 1, 8'h11, 1);

    tick();
    for (int i = 0; i < 33; i++) begin
      RST = tbl[i].rst; REQ = tbl[i].req; Y_READY = tbl[i].rdy;
      #3;
      chk($sformatf("v%0d GNT", i),     GNT,     tbl[i].e_gnt);
      chk($sformatf("v%0d SEL", i),     SEL,     tbl[i].e_sel);
      chk($sformatf("v%0d Y_VALID", i), Y_VALID, tbl[i].e_yv);
      chk($sformatf("v%0d Y", i),       Y,       tbl[i].e_y);
      chk($sformatf("v%0d BUSY", i),    BUSY,    tbl[i].e_busy);
      tick();
    end

    // round-robin with all 8 requesting: grant k for 4 cycles after each idle cycle
    RST = 1'b1; REQ = 8'hFF; Y_READY = 1'b1;
    tick();
    RST = 1'b0;
    beats = 0;
    for (int c = 0; c < 45; c++) begin
      #3;
      lane = (c / 5) % 8;
      eg = (c % 5 == 0) ? 8'h00 : (8'h01 << lane);
      chk($sformatf("rr c%0d GNT", c), GNT, eg);
      if (c % 5 != 0) chk($sformatf("rr c%0d SEL", c), SEL, lane);
      if (c < 40 && Y_VALID && Y_READY) beats++;
      tick();
    end
    chk("rr beats in 40 cycles", beats, 32);

    // async reset mid-burst on lane 3 with two beats taken
    RST = 1'b1; REQ = 8'h08;
    tick();
    RST = 1'b0;
    tick();
    tick();
    tick();
    #3;
    chk("ar pre SEL", SEL, 3);
    chk("ar pre GNT", GNT, 8'h08);
    RST = 1'b1;
    #1;
    chk("ar GNT", GNT, 8'h00);
    chk("ar SEL", SEL, 0);
    chk("ar Y_VALID", Y_VALID, 0);
    chk("ar BUSY", BUSY, 0);
    REQ = 8'h09;
    tick();
    RST = 1'b0;
    #3;
    chk("ar post idle GNT", GNT, 8'h00);
    tick();
    #3;
    chk("ar post GNT", GNT, 8'h01);
    chk("ar post SEL", SEL, 0);
    chk("ar post Y", Y, 8'h11);
    tick();

    // BURST_MAX=1 instance: REQ=03 alternates 0,1,0,1 with an idle cycle between
    b_req = 8'h03; b_rdy = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      #3;
      lane = ((c - 1) / 2) % 2;
      eg = (c % 2 == 0) ? 8'h00 : (8'h01 << lane);
      chk($sformatf("b1 c%0d GNT", c), b_gnt, eg);
      chk($sformatf("b1 c%0d Y_VALID", c), b_yv, (c % 2 == 1));
      if (c % 2 == 1) chk($sformatf("b1 c%0d Y", c), b_y, (lane == 0) ? 8'h11 : 8'h22);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mux8_arbiter.md
Name: rr_mux8_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 8-input, W-bit select datapath. It grants one of 8 requesters at a time and drives the 3-bit select. It gates the selected data onto a single valid/ready output channel. It limits each grant to BURST_MAX accepted beats so that every requester gets bounded service.

Parameters:
W, 8, data width of each requester input and of Y.
BURST_MAX, 4, maximum beats accepted per grant; legal range 1..255.

Ports:
CLK  input  1  system clock; all state updates on its rising edge.
RST  input  1  asynchronous, active-high reset.
REQ  input  8  per-requester request; bit i high means requester i has a beat on its DIN lane.
DIN  input  8*W  packed requester data; lane i is DIN[i*W +: W].
Y_READY  input  1  downstream accepts Y this cycle.
Y  output  W  selected data; forced to 0 when Y_VALID=0.
Y_VALID  output  1  Y holds a valid beat.
SEL  output  3  registered index of the current or most recent grant holder.
GNT  output  8  registered one-hot grant; all zero when idle.
BUSY  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - SEL=0, GNT=0, BUSY=0.
  - Beat count=0.
  - Priority pointer PTR=7, so requester 0 has the highest priority first.
  - Y_VALID=0, Y=0.
- Reset asserted mid-grant aborts the grant immediately with no further beats. Arbitration restarts from PTR=7 after release.
- State IDLE:
  - GNT=0, Y_VALID=0.
  - If REQ != 0, the winner is the first set bit scanning (PTR+1), (PTR+2), … mod 8.
  - On the next edge: state becomes GRANT, SEL=winner, GNT=1<<winner, count=0.
  - If REQ == 0, state stays IDLE and SEL holds its value.
- State GRANT:
  - Y_VALID = REQ[SEL], combinational.
  - Y = DIN lane SEL when Y_VALID, else 0.
  - A beat is accepted in a cycle where Y_VALID && Y_READY; accepting increments count.
- Exit from GRANT to IDLE, on the edge ending the cycle in which either holds:
  - (a) REQ[SEL]==0 (requester withdrew; no beat taken that cycle), or
  - (b) a beat is accepted and count==BURST_MAX-1.
- On exit:
  - PTR=SEL.
  - GNT=0 and count=0 from the next cycle.
  - SEL keeps its value.
- Grant latency: 1 cycle from REQ seen in IDLE to GNT/Y_VALID.
- Turnaround: exactly one IDLE cycle between consecutive grants, including re-grant of the same requester.
- Maximum throughput: BURST_MAX beats per BURST_MAX+1 cycles when all requesters are continuously active.
- Back-pressure: while Y_READY=0, Y and Y_VALID hold as long as the requester holds REQ and DIN. Count does not advance and there is no timeout.
- Requests on lanes other than SEL during GRANT are ignored. They are not latched; a requester must hold REQ to be considered.
- REQ[SEL] dropping and re-rising within a grant is impossible to observe: the grant ends on the first low cycle.
- Fairness:
  - With all 8 requesting continuously, the grant order is 0,1,2,…,7,0,…
  - A single requester alone is re-granted after each one-cycle IDLE gap.
- Count is 8 bits. BURST_MAX=1 means one beat per grant.
- GNT is always zero or one-hot. GNT != 0 exactly when BUSY=1.

Test Plan:
- Reset then single requester: after RST release, REQ=8'h04, DIN lane2=8'hA5, Y_READY=1 -> cycle 1 GNT=8'h04, SEL=2, Y=8'hA5, Y_VALID=1. After 4 accepted beats GNT=0 for 1 cycle, then re-granted.
- Round-robin fairness: REQ=8'hFF held, Y_READY=1, BURST_MAX=4 -> SEL sequence 0,1,…,7,0. Each grant lasts 4 beats followed by 1 IDLE cycle; 40 cycles yield 32 beats.
- Back-pressure: grant to lane 5, Y_READY=0 for 6 cycles, then 1 -> Y and Y_VALID are stable for those 6 cycles and count stays 0. The grant ends after 4 accepted beats.
- Withdrawal and pointer: REQ=8'h81, lane 0 granted, lane 0 drops REQ after 2 beats -> next cycle IDLE, then grant to lane 7 (not lane 0). Y=0 whenever Y_VALID=0.
- Async reset mid-burst: assert RST between edges during a grant to lane 3 with count=2 -> GNT=0, SEL=0, Y_VALID=0 immediately. After release with REQ=8'h09, lane 0 wins first.
- BURST_MAX=1 build: REQ=8'h03 -> strictly alternating grants 0,1,0,1 with one beat per grant.
